mantissa_div_seq: RTL

- Sequential, parametrised mantissa divider with valid/ready handshakes; next generation of the fixed-width FP-divide mantissa path.
- Computes (1.m1)/(1.m2) by radix-2 restoring digit recurrence with an exact remainder, so the sticky bit is exact.
- Supports four IEEE rounding modes using the result sign, normalises the result and reports exponent decrement and inexact.
- Sits between operand unpack and exponent/pack logic in the FP divide datapath.

---
 rtl/mant_div_pkg.sv | 23 ++
 rtl/mant_round.sv | 33 +++
 rtl/mantissa_div_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mant_div_pkg.sv
// rtl/mant_div_pkg.sv - shared types and sizing helper for the sequential mantissa divider
package mant_div_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    ROUND = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Integer bit, WIDTH fraction bits, guard bit and one spare for the q < 1 shift.
  function automatic int qbits_f(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/mant_round.sv
// rtl/mant_round.sv - combinational IEEE rounding of a normalised fraction with guard/sticky
module mant_round
  import mant_div_pkg::*;
#(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0] i_frac,
  input  logic             i_guard,
  input  logic             i_sticky,
  input  logic             i_sign,
  input  rm_t              i_rm,
  output logic [WIDTH-1:0] o_frac,
  output logic             o_carry,
  output logic             o_inexact
);

  logic w_inc;

  always_comb begin
    w_inc = 1'b0;
    unique case (i_rm)
      RM_RNE:  w_inc = i_guard & (i_sticky | i_frac[0]);
      RM_RZ:   w_inc = 1'b0;
      RM_RDN:  w_inc = i_sign & (i_guard | i_sticky);
      RM_RUP:  w_inc = ~i_sign & (i_guard | i_sticky);
      default: w_inc = 1'b0;
    endcase
  end

  assign {o_carry, o_frac} = {1'b0, i_frac} + {{WIDTH{1'b0}}, w_inc};
  assign o_inexact         = i_guard | i_sticky;

endmodule

// File: rtl/mantissa_div_seq.sv
// rtl/mantissa_div_seq.sv - radix-2 restoring (1.m1)/(1.m2) with rounding; MANT_DIV_EARLY_TERM_EN enables exact-remainder early exit
module mantissa_div_seq
  import mant_div_pkg::*;
#(
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] m2,
  input  logic             sign,
  input  logic [1:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] m3,
  output logic             decrement_exponent,
  output logic             inexact
);

  localparam int QBITS = qbits_f(WIDTH);
  localparam int RW    = WIDTH + 3;
  localparam int CW    = $clog2(QBITS);

  state_t             r_state, w_state_next;
  logic [WIDTH+1:0]   r_y;
  logic [RW-1:0]      r_r;
  logic [QBITS-1:0]   r_q;
  logic [CW-1:0]      r_cnt;
  logic               r_sign;
  rm_t                r_rm;
  logic [WIDTH-1:0]   r_m3;
  logic               r_dec;
  logic               r_inexact;

  logic               w_ge;
  logic [RW-1:0]      w_diff;
  logic [RW-1:0]      w_r_next;
  logic [QBITS-1:0]   w_q_next;
  logic               w_early;
  logic [WIDTH-1:0]   w_frac;
  logic               w_guard;
  logic               w_sticky;
  logic               w_dec;
  logic [WIDTH-1:0]   w_frac_rnd;
  logic               w_carry;
  logic               w_inexact;

  // R stays below 2Y throughout, so RW bits hold R and both shifted candidates.
  assign w_ge     = (r_r >= {1'b0, r_y});
  assign w_diff   = r_r - {1'b0, r_y};
  assign w_r_next = w_ge ? (w_diff << 1) : (r_r << 1);
  assign w_q_next = {r_q[QBITS-2:0], w_ge};

`ifdef MANT_DIV_EARLY_TERM_EN
  assign w_early = w_ge && (w_diff == '0);
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    if (r_q[QBITS-1]) begin
      w_frac   = r_q[QBITS-2 -: WIDTH];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (|r_r);
      w_dec    = 1'b0;
    end else begin
      w_frac   = r_q[QBITS-3 -: WIDTH];
      w_guard  = r_q[0];
      w_sticky = |r_r;
      w_dec    = 1'b1;
    end
  end

  mant_round #(.WIDTH(WIDTH)) u_round (
    .i_frac    (w_frac),
    .i_guard   (w_guard),
    .i_sticky  (w_sticky),
    .i_sign    (r_sign),
    .i_rm      (r_rm),
    .o_frac    (w_frac_rnd),
    .o_carry   (w_carry),
    .o_inexact (w_inexact)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_early || (r_cnt == '0)) w_state_next = ROUND;
      end
      ROUND: w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_y       <= '0;
      r_r       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_rm      <= RM_RNE;
      r_m3      <= '0;
      r_dec     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_y    <= {2'b01, m2};
            r_r    <= {1'b0, 2'b01, m1};
            r_q    <= '0;
            r_cnt  <= CW'(QBITS - 1);
            r_sign <= sign;
            r_rm   <= rm_t'(rm);
          end
        end
        RUN: begin
          r_r   <= w_r_next;
          // An exact zero remainder means every remaining quotient bit is 0.
          r_q   <= w_early ? (w_q_next << r_cnt) : w_q_next;
          r_cnt <= r_cnt - CW'(1);
        end
        ROUND: begin
          assert (!w_carry);
          r_m3      <= w_frac_rnd;
          r_dec     <= w_dec;
          r_inexact <= w_inexact;
        end
        default: ;
      endcase
    end
  end

  assign m3                 = r_m3;
  assign decrement_exponent = r_dec;
  assign inexact            = r_inexact;

endmodule
